bnn_conv_sched: RTL

Sequencer for the single binary 5x5 convolution engine and its sliding-window front end. On one layer command it walks every output kernel of the selected layer. Per kernel it streams 25 one-bit weights from the weight ROM into the engine, starts the window generator, and writes each valid output to the feature buffer. It then waits for the engine's done pulse, checks the output count and moves to the next kernel. It sits between the top-level layer FSM and the conv/window/ROM/buffer resources.

---
 rtl/bnn_conv_sched.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/bnn_conv_sched.sv
`default_nettype none
// ============================================================================
// Module   : bnn_conv_sched
// Brief    : Per-layer kernel sequencer feeding the binary 5x5 conv engine,
//            its window generator, the weight ROM and the feature buffer.
// Revision : 1.0 - initial release
// ============================================================================
module bnn_conv_sched #(
    parameter int K        = 5,
    parameter int N_KER_L1 = 6,
    parameter int N_KER_L2 = 12,
    parameter int L2_WBASE = 150,
    parameter int N_OUT_L1 = 576,
    parameter int N_OUT_L2 = 64,
    parameter int WIN_LAG  = 2,
    parameter int TIMEOUT  = 4095,
    parameter int WA_W     = 10,
    parameter int OA_W     = 13
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            cmd_valid,
    input  logic            cmd_layer,
    output logic            cmd_ready,
    output logic            busy,
    output logic            layer_done,
    output logic            err,
    output logic            wt_rd_en,
    output logic [WA_W-1:0] wt_addr,
    input  logic            wt_bit,
    output logic            conv_start,
    output logic            conv_weight_en,
    output logic            conv_weight,
    output logic            conv_state,
    output logic            win_start,
    input  logic            conv_ovalid,
    input  logic            conv_done,
    output logic            out_we,
    output logic [OA_W-1:0] out_addr,
    output logic [3:0]      kernel_idx
);

    localparam int J_W  = $clog2(K * K);
    localparam int RC_W = $clog2(TIMEOUT + 1);

    localparam logic [J_W-1:0]  c_j_last   = J_W'(K * K - 1);
    localparam logic [J_W-1:0]  c_win_lag  = J_W'(WIN_LAG);
    localparam logic [RC_W-1:0] c_run_last = RC_W'(TIMEOUT - 1);
    localparam logic [3:0]      c_last_l1  = 4'(N_KER_L1 - 1);
    localparam logic [3:0]      c_last_l2  = 4'(N_KER_L2 - 1);
    localparam logic [OA_W-1:0] c_nout_l1  = OA_W'(N_OUT_L1);
    localparam logic [OA_W-1:0] c_nout_l2  = OA_W'(N_OUT_L2);
    localparam logic [WA_W-1:0] c_l2_base  = WA_W'(L2_WBASE);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREF = 3'd1,
        S_LOAD = 3'd2,
        S_RUN  = 3'd3,
        S_GAP  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_layer;
    logic [3:0]      r_kidx;
    logic [J_W-1:0]  r_j;
    logic [WA_W-1:0] r_wt_addr;
    logic [OA_W-1:0] r_out_addr;
    logic [OA_W-1:0] r_ocnt;
    logic [RC_W-1:0] r_run_cnt;
    logic            r_err;

    logic            w_last_ker;
    logic            w_timeout;
    logic            w_cnt_bad;
    logic [OA_W-1:0] w_nout;
    logic [OA_W-1:0] w_ocnt_final;

    assign w_last_ker   = (r_kidx == (r_layer ? c_last_l2 : c_last_l1));
    assign w_timeout    = (r_run_cnt == c_run_last);
    assign w_nout       = r_layer ? c_nout_l2 : c_nout_l1;
    // An output arriving together with conv_done still belongs to this kernel.
    assign w_ocnt_final = r_ocnt + {{(OA_W-1){1'b0}}, conv_ovalid};
    assign w_cnt_bad    = (w_ocnt_final != w_nout);

    assign wt_addr    = wt_rd_en ? r_wt_addr : '0;
    assign conv_state = r_layer;
    assign err        = r_err;
    assign out_addr   = r_out_addr;
    assign kernel_idx = r_kidx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        cmd_ready      = 1'b0;
        busy           = 1'b1;
        layer_done     = 1'b0;
        wt_rd_en       = 1'b0;
        conv_start     = 1'b0;
        conv_weight_en = 1'b0;
        conv_weight    = 1'b0;
        win_start      = 1'b0;
        out_we         = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) w_state_nxt = S_PREF;
            end
            S_PREF: begin
                wt_rd_en    = 1'b1;
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                conv_start     = 1'b1;
                conv_weight_en = 1'b1;
                conv_weight    = wt_bit;
                wt_rd_en       = (r_j != c_j_last);
                win_start      = (r_j >= c_win_lag);
                if (r_j == c_j_last) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                conv_start = 1'b1;
                win_start  = 1'b1;
                out_we     = conv_ovalid;
                if (conv_done)      w_state_nxt = S_GAP;
                else if (w_timeout) w_state_nxt = S_FIN;
            end
            S_GAP: begin
                w_state_nxt = w_last_ker ? S_FIN : S_PREF;
            end
            S_FIN: begin
                layer_done  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_layer    <= 1'b0;
            r_kidx     <= '0;
            r_j        <= '0;
            r_wt_addr  <= '0;
            r_out_addr <= '0;
            r_ocnt     <= '0;
            r_run_cnt  <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_layer    <= cmd_layer;
                        r_kidx     <= '0;
                        r_out_addr <= '0;
                        r_err      <= 1'b0;
                        r_wt_addr  <= cmd_layer ? c_l2_base : '0;
                    end
                end
                S_PREF: begin
                    r_j       <= '0;
                    r_ocnt    <= '0;
                    r_run_cnt <= '0;
                end
                S_LOAD: begin
                    r_j <= r_j + J_W'(1);
                end
                S_RUN: begin
                    r_run_cnt <= r_run_cnt + RC_W'(1);
                    if (conv_ovalid) begin
                        r_out_addr <= r_out_addr + OA_W'(1);
                        r_ocnt     <= r_ocnt + OA_W'(1);
                    end
                    if (conv_done) begin
                        if (w_cnt_bad) r_err <= 1'b1;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (!w_last_ker) r_kidx <= r_kidx + 4'd1;
                end
                default: begin
                end
            endcase
            // 25 reads (PREF + 24 LOAD) leave the pointer on the next kernel's base.
            if (wt_rd_en) r_wt_addr <= r_wt_addr + WA_W'(1);
        end
    end

endmodule
`default_nettype wire
